jtdsp16_xaau_nest: RTL

Next-generation ROM address arithmetic unit (XAAU) for the JTDSP16 core. It generates the program fetch address and owns PC, PT, PI and I. It adds three things over the single-level unit: a parametrised return stack (replacing the single PR), nestable do-loops with hardware loop-end detection, and prioritised multi-source interrupts. It sits between the instruction decoder and program ROM.

---
 rtl/jtdsp16_xaau_pkg.sv | 30 +++
 rtl/jtdsp16_lifo.sv | 64 ++++++
 rtl/jtdsp16_xaau_nest.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/jtdsp16_xaau_pkg.sv
// Shared types and constants for the nested-loop JTDSP16 ROM address unit.
// Loop-stack entries hold 16-bit addresses, so the unit supports AW up to 16.
package jtdsp16_xaau_pkg;

  typedef enum logic [1:0] {
    RF_PT = 2'd0,
    RF_RS = 2'd1,
    RF_PI = 2'd2,
    RF_I  = 2'd3
  } rfield_e;

  localparam int ERR_RS_OVF = 0;
  localparam int ERR_RS_UNF = 1;
  localparam int ERR_LOOP   = 2;

  localparam int LA_W = 16;
  localparam int LC_W = 7;
  localparam int I_W  = 12;

  typedef struct packed {
    logic [LA_W-1:0] head;
    logic [LA_W-1:0] tail;
    logic [LC_W-1:0] count;
  } loop_ent_t;

  function automatic logic [15:0] sext_i(input logic [I_W-1:0] v);
    return {{(16-I_W){v[I_W-1]}}, v};
  endfunction

endpackage

// File: rtl/jtdsp16_lifo.sv
// Circular LIFO: a push onto a full stack silently drops the oldest entry,
// a pop of an empty stack is ignored, and an empty stack reads as zero.
module jtdsp16_lifo #(
  parameter int W = 16,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cen,
  input  logic         push,
  input  logic         pop,
  input  logic         ovr,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full
);

  localparam int PW = (D > 1) ? $clog2(D) : 1;
  localparam int CW = $clog2(D + 1);

  logic [W-1:0]  mem [D];
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic [PW-1:0] ptr_prv;
  logic [CW-1:0] cnt;

  always_comb begin
    ptr_nxt = (ptr == PW'(D - 1)) ? '0 : ptr + PW'(1);
    ptr_prv = (ptr == '0) ? PW'(D - 1) : ptr - PW'(1);
  end

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(D));
  assign top   = empty ? '0 : mem[ptr_prv];

  // ptr always points at the next free slot; the count saturates at D so the
  // pointer keeps rotating over the oldest entry on overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      cnt <= '0;
      for (int k = 0; k < D; k++) mem[k] <= '0;
    end else if (cen) begin
      if (flush) begin
        ptr <= '0;
        cnt <= '0;
      end else if (push) begin
        mem[ptr] <= din;
        ptr      <= ptr_nxt;
        if (!full) cnt <= cnt + CW'(1);
      end else if (pop) begin
        if (!empty) begin
          ptr <= ptr_prv;
          cnt <= cnt - CW'(1);
        end
      end else if (ovr) begin
        mem[ptr_prv] <= din;
      end
    end
  end

endmodule

// File: rtl/jtdsp16_xaau_nest.sv
// JTDSP16 ROM address unit with a return stack, nestable hardware do-loops
// and prioritised multi-source interrupts. Owns PC, PT, PI and I.
module jtdsp16_xaau_nest
  import jtdsp16_xaau_pkg::*;
#(
  parameter  int AW   = 16,
  parameter  int RSD  = 4,
  parameter  int LD   = 2,
  parameter  int NIRQ = 2,
  parameter  int IVEC = 1,
  localparam int IDW  = (NIRQ > 1) ? $clog2(NIRQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cen,
  input  logic            goto_ja,
  input  logic            call_ja,
  input  logic            goto_pt,
  input  logic            call_pt,
  input  logic            ret,
  input  logic            iret,
  input  logic [11:0]     jfield,
  input  logic            pc_halt,
  input  logic [1:0]      r_field,
  input  logic            ld_en,
  input  logic [15:0]     ld_data,
  input  logic            pt_post,
  input  logic            istep,
  input  logic            do_start,
  input  logic [3:0]      do_len,
  input  logic [6:0]      do_cnt,
  input  logic [NIRQ-1:0] irq,
  input  logic            no_int,
  output logic [AW-1:0]   rom_addr,
  output logic [AW-1:0]   pt_addr,
  output logic [15:0]     reg_dout,
  output logic            iack,
  output logic [IDW-1:0]  iack_id,
  output logic            in_irq,
  output logic            loop_act,
  output logic [2:0]      err
);

  logic [AW-1:0]  pc;
  logic [AW-1:0]  pt;
  logic [AW-1:0]  pi;
  logic [I_W-1:0] i_reg;

  logic [AW-1:0]  pc_inc;
  logic [AW-1:0]  jtarget;
  logic [AW-1:0]  do_end;
  logic [AW-1:0]  lp_head;
  logic [AW-1:0]  lp_end;
  logic [AW-1:0]  seq_pc;
  logic [AW-1:0]  vec_pc;
  logic [AW-1:0]  next_pc;
  logic [AW-1:0]  pt_step;
  logic [IDW-1:0] irq_id;

  logic cf_jump;
  logic cf_any;
  logic do_try;
  logic do_rej;
  logic do_ok;
  logic at_end;
  logic ls_step;
  logic lp_more;
  logic enter_int;

  logic           rs_push;
  logic           rs_ovr;
  logic [AW-1:0]  rs_din;
  logic [AW-1:0]  rs_top;
  logic           rs_empty;
  logic           rs_full;

  logic      ls_push;
  logic      ls_pop;
  logic      ls_ovr;
  logic      ls_flush;
  loop_ent_t ls_din;
  loop_ent_t ls_top;
  logic      ls_empty;
  logic      ls_full;

  assign cf_jump = goto_ja | call_ja | goto_pt | call_pt;
  assign cf_any  = cf_jump | ret | iret;

  assign pc_inc  = pc + AW'(1);
  assign jtarget = (goto_pt | call_pt) ? pt : {pc[AW-1:12], jfield};
  assign do_end  = pc + AW'(do_len);
  assign lp_head = AW'(ls_top.head);
  assign lp_end  = AW'(ls_top.tail);
  assign lp_more = (ls_top.count > LC_W'(1));

  assign loop_act = !ls_empty;
  assign at_end   = loop_act && (pc == lp_end);
  assign ls_step  = at_end && !cf_any && !pc_halt;

  // A new loop must end strictly inside the enclosing body, and cannot be
  // pushed onto a full loop stack; a rejected do behaves as a nop.
  assign do_try = do_start && !cf_any && !pc_halt;
  assign do_rej = ls_full || (loop_act && (do_end >= lp_end));
  assign do_ok  = do_try && !do_rej;

  assign enter_int = (|irq) && !in_irq && !pc_halt && !no_int && !loop_act && !cf_any;

  always_comb begin
    irq_id = '0;
    for (int k = NIRQ - 1; k >= 0; k--) begin
      if (irq[k]) irq_id = IDW'(k);
    end
  end

  assign vec_pc = AW'(IVEC) + AW'(irq_id);

  // seq_pc is where the program goes when no control-flow input intervenes;
  // it is also the return point captured into PI on interrupt entry.
  always_comb begin
    if (pc_halt)                    seq_pc = pc;
    else if (do_ok && do_cnt == '0) seq_pc = do_end + AW'(1);
    else if (ls_step && lp_more)    seq_pc = lp_head;
    else                            seq_pc = pc_inc;
  end

  always_comb begin
    if (enter_int)    next_pc = vec_pc;
    else if (cf_jump) next_pc = jtarget;
    else if (ret)     next_pc = rs_top;
    else if (iret)    next_pc = pi;
    else              next_pc = seq_pc;
  end

  assign rs_push = call_ja | call_pt;
  assign rs_ovr  = ld_en && (r_field == RF_RS);
  assign rs_din  = rs_push ? pc_inc : AW'(ld_data);

  jtdsp16_lifo #(
    .W (AW),
    .D (RSD)
  ) u_rstack (
    .clk   (clk),
    .rst   (rst),
    .cen   (cen),
    .push  (rs_push),
    .pop   (ret),
    .ovr   (rs_ovr),
    .flush (1'b0),
    .din   (rs_din),
    .top   (rs_top),
    .empty (rs_empty),
    .full  (rs_full)
  );

  assign ls_flush = loop_act && cf_any;
  assign ls_push  = do_ok && (do_cnt != '0);
  assign ls_pop   = ls_step && !lp_more;
  assign ls_ovr   = ls_step && lp_more;

  always_comb begin
    if (ls_push) begin
      ls_din.head  = LA_W'(pc_inc);
      ls_din.tail  = LA_W'(do_end);
      ls_din.count = do_cnt;
    end else begin
      ls_din.head  = ls_top.head;
      ls_din.tail  = ls_top.tail;
      ls_din.count = ls_top.count - LC_W'(1);
    end
  end

  jtdsp16_lifo #(
    .W ($bits(loop_ent_t)),
    .D (LD)
  ) u_lstack (
    .clk   (clk),
    .rst   (rst),
    .cen   (cen),
    .push  (ls_push),
    .pop   (ls_pop),
    .ovr   (ls_ovr),
    .flush (ls_flush),
    .din   (ls_din),
    .top   (ls_top),
    .empty (ls_empty),
    .full  (ls_full)
  );

  assign pt_step = istep ? AW'($signed(i_reg)) : AW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= '0;
      pt      <= '0;
      pi      <= '0;
      i_reg   <= '0;
      err     <= '0;
      in_irq  <= 1'b0;
      iack    <= 1'b0;
      iack_id <= '0;
    end else if (cen) begin
      pc <= next_pc;

      if (ld_en && r_field == RF_PT) pt <= AW'(ld_data);
      else if (pt_post)              pt <= pt + pt_step;

      if (ld_en && r_field == RF_PI) pi <= AW'(ld_data);
      else if (enter_int)            pi <= seq_pc;

      if (ld_en && r_field == RF_I) i_reg <= ld_data[I_W-1:0];

      if (rs_push && rs_full)  err[ERR_RS_OVF] <= 1'b1;
      if (ret && rs_empty)     err[ERR_RS_UNF] <= 1'b1;
      if (do_try && do_rej)    err[ERR_LOOP]   <= 1'b1;

      if (enter_int) in_irq <= 1'b1;
      else if (iret) in_irq <= 1'b0;

      iack <= enter_int;
      if (enter_int) iack_id <= irq_id;
    end
  end

  assign rom_addr = pc;
  assign pt_addr  = pt;

  always_comb begin
    case (r_field)
      RF_PT:   reg_dout = 16'(pt);
      RF_RS:   reg_dout = 16'(rs_top);
      RF_PI:   reg_dout = 16'(pi);
      default: reg_dout = sext_i(i_reg);
    endcase
  end

endmodule
